// File: rtl/quat_pkg.sv
// Shared constants and helpers for the quarter-pel interpolation pipe.
// best_to_rc maps a 3x3 half-pel best index onto the 5x5 window centre.
package quat_pkg;

    localparam int NBR = 9;
    localparam int WIN = 25;
    localparam logic [3:0] BEST_CTR = 4'd4;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] c;
    } rc_t;

    function automatic rc_t best_to_rc(input logic [3:0] b);
        rc_t        rc;
        logic [3:0] q3;
        logic [3:0] m3;
        q3   = b / 4'd3;
        m3   = b % 4'd3;
        rc.r = 3'd1 + q3[2:0];
        rc.c = 3'd1 + m3[2:0];
        return rc;
    endfunction

endpackage

// File: rtl/quat_avg.sv
// Rounded two-input average (a + b + 1) >> 1 on a PIX_W+1-bit sum.
module quat_avg #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] y
);

    assign y = PIX_W'(({1'b0, a} + {1'b0, b} + (PIX_W+1)'(1)) >> 1);

endmodule

// File: rtl/quat_ip_pipe.sv
// Two-stage quarter-pel candidate generator: S1 picks the 3x3 neighbourhood
// around the best half-pel, S2 registers the rounded averages.
module quat_ip_pipe
    import quat_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int LANES = 4,
    parameter int BEATS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_first,
    input  logic [3:0]                   in_best,
    input  logic [LANES*WIN*PIX_W-1:0]   in_win,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*NBR*PIX_W-1:0]   out_quat,
    output logic                         out_last,
    output logic [3:0]                   out_best,
    output logic                         sync_err
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

    logic            s1_valid;
    logic            s2_adv;
    logic            acc;
    logic [CW-1:0]   cnt_q;
    logic            open_q;
    logic [3:0]      best_q;
    logic            bad_best;
    logic [3:0]      beat_best;
    logic [CW-1:0]   beat_idx;
    logic            beat_last;
    logic            beat_err;
    logic            beat_framed;
    rc_t             rc;

    logic [PIX_W-1:0] sel    [LANES][NBR];
    logic [PIX_W-1:0] s1_pix [LANES][NBR];
    logic [3:0]       s1_best;
    logic             s1_last;
    logic [LANES*NBR*PIX_W-1:0] q_d;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = rst_n && (!s1_valid || s2_adv);
    assign acc      = in_valid && in_ready;

    always_comb begin
        bad_best    = in_best > 4'd8;
        beat_best   = best_q;
        beat_idx    = cnt_q;
        beat_err    = 1'b0;
        beat_framed = 1'b1;
        if (in_first) begin
            beat_best = bad_best ? BEST_CTR : in_best;
            beat_idx  = '0;
            beat_err  = bad_best || (cnt_q != '0);
        end else if (!open_q) begin
            // orphan beat outside any block
            beat_best   = BEST_CTR;
            beat_err    = 1'b1;
            beat_framed = 1'b0;
        end
        beat_last = (beat_idx == LAST_IDX);
    end

    assign rc = best_to_rc(beat_best);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            for (int j = 0; j < NBR; j++) begin
                sel[l][j] = in_win[(l*WIN + (int'(rc.r) + j/3 - 1)*5
                                   + int'(rc.c) + j%3 - 1)*PIX_W +: PIX_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            open_q   <= 1'b0;
            best_q   <= BEST_CTR;
            sync_err <= 1'b0;
        end else if (acc) begin
            if (beat_err) sync_err <= 1'b1;
            if (in_first) best_q <= beat_best;
            if (beat_framed) begin
                cnt_q  <= beat_last ? '0 : beat_idx + 1'b1;
                open_q <= !beat_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_best  <= BEST_CTR;
            s1_last  <= 1'b0;
            for (int l = 0; l < LANES; l++)
                for (int j = 0; j < NBR; j++)
                    s1_pix[l][j] <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_best <= beat_best;
                s1_last <= beat_last;
                s1_pix  <= sel;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar j = 0; j < NBR; j++) begin : g_nbr
            if (j == 4) begin : g_ctr
                assign q_d[(l*NBR+j)*PIX_W +: PIX_W] = s1_pix[l][4];
            end else begin : g_avg
                quat_avg #(.PIX_W(PIX_W)) u_avg (
                    .a (s1_pix[l][4]),
                    .b (s1_pix[l][j]),
                    .y (q_d[(l*NBR+j)*PIX_W +: PIX_W])
                );
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_quat  <= '0;
            out_last  <= 1'b0;
            out_best  <= BEST_CTR;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_quat <= q_d;
                out_last <= s1_last;
                out_best <= s1_best;
            end
        end
    end

endmodule

// File: tb/tb_quat_ip_pipe.sv
// Scoreboard bench for quat_ip_pipe: expected beats are queued on acceptance
// and compared when the DUT hands them out.
module tb_quat_ip_pipe;

    localparam int PIX_W = 8;
    localparam int LANES = 4;
    localparam int BEATS = 4;
    localparam int WW    = LANES*25*PIX_W;
    localparam int QW    = LANES*9*PIX_W;

    typedef logic [WW-1:0] win_t;
    typedef struct {
        logic [QW-1:0] q;
        logic          last;
        logic [3:0]    best;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_first;
    logic [3:0]    in_best;
    win_t          in_win;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] out_quat;
    logic          out_last;
    logic [3:0]    out_best;
    logic          sync_err;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic          hold_prev = 1'b0;
    logic [QW-1:0] prev_q;
    logic          prev_last;
    logic [3:0]    prev_best;
    win_t          w;

    always #5 clk = ~clk;

    quat_ip_pipe #(.PIX_W(PIX_W), .LANES(LANES), .BEATS(BEATS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_best   (in_best),
        .in_win    (in_win),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quat  (out_quat),
        .out_last  (out_last),
        .out_best  (out_best),
        .sync_err  (sync_err)
    );

    task automatic check(input string tag, input logic [QW-1:0] got,
                         input logic [QW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic win_t put(input win_t wi, input int l, input int r,
                                 input int c, input int v);
        win_t wo = wi;
        wo[(l*25 + r*5 + c)*PIX_W +: PIX_W] = PIX_W'(v);
        return wo;
    endfunction

    function automatic win_t fill(input int v);
        win_t wo;
        for (int i = 0; i < LANES*25; i++) wo[i*PIX_W +: PIX_W] = PIX_W'(v);
        return wo;
    endfunction

    function automatic win_t rand_win();
        win_t wo;
        for (int i = 0; i < LANES*25; i++)
            wo[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
        return wo;
    endfunction

    function automatic logic [QW-1:0] model(input win_t wi, input int b);
        logic [QW-1:0] q = '0;
        int cr, cc, ctr, nb, s;
        cr = 1 + b/3;
        cc = 1 + b%3;
        for (int l = 0; l < LANES; l++) begin
            ctr = int'(wi[(l*25 + cr*5 + cc)*PIX_W +: PIX_W]);
            for (int j = 0; j < 9; j++) begin
                nb = int'(wi[(l*25 + (cr + j/3 - 1)*5 + cc + j%3 - 1)*PIX_W +: PIX_W]);
                s  = (ctr + nb + 1) / 2;
                q[(l*9 + j)*PIX_W +: PIX_W] = (j == 4) ? PIX_W'(ctr) : PIX_W'(s);
            end
        end
        return q;
    endfunction

    task automatic send(input logic f, input logic [3:0] b, input win_t wi,
                        input logic [3:0] eb, input logic el);
        bit ok = 0;
        in_valid = 1'b1;
        in_first = f;
        in_best  = b;
        in_win   = wi;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (ok) sb.push_back('{q: model(wi, int'(eb)), last: el, best: eb});
        else check("send_timeout", in_ready, 1);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("sb_left", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && hold_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_quat", out_quat, prev_q);
            check("hold_last", out_last, prev_last);
            check("hold_best", out_best, prev_best);
        end
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", out_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                check("quat", out_quat, mon_e.q);
                check("last", out_last, mon_e.last);
                check("best", out_best, mon_e.best);
            end
        end
        hold_prev = rst_n && out_valid && !out_ready;
        prev_q    = out_quat;
        prev_last = out_last;
        prev_best = out_best;
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_best   = '0;
        in_win    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_out_quat", out_quat, 0);
        check("rst_out_last", out_last, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // centre 200 against 100s, best 0
        w = fill(100);
        for (int l = 0; l < LANES; l++) w = put(w, l, 1, 1, 200);
        send(1, 4'd0, w, 4'd0, 0);
        check("lat1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat2_valid", out_valid, 1);
        check("q4_ctr", out_quat[4*PIX_W +: PIX_W], 200);
        check("q0_avg", out_quat[0 +: PIX_W], 150);
        check("q8_avg", out_quat[8*PIX_W +: PIX_W], 150);
        send(0, 4'd5, rand_win(), 4'd0, 0);
        send(0, 4'd5, rand_win(), 4'd0, 0);
        send(0, 4'd5, rand_win(), 4'd0, 1);

        // rounding at the top and bottom of the range
        w = rand_win();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                w = put(w, 0, r, c, 254);
                w = put(w, 1, r, c, 1);
            end
        w = put(w, 0, 2, 2, 255);
        w = put(w, 1, 2, 2, 0);
        send(1, 4'd4, w, 4'd4, 0);
        send(0, 4'd4, rand_win(), 4'd4, 0);
        send(0, 4'd4, rand_win(), 4'd4, 0);
        send(0, 4'd4, rand_win(), 4'd4, 1);
        drain();
        check("err_clean", sync_err, 0);

        // best latched from first beat
        send(1, 4'd8, rand_win(), 4'd8, 0);
        send(0, 4'd0, rand_win(), 4'd8, 0);
        send(0, 4'd0, rand_win(), 4'd8, 0);
        send(0, 4'd0, rand_win(), 4'd8, 1);
        drain();
        check("err_after_8", sync_err, 0);

        // out-of-range best, then restart mid-block
        send(1, 4'd12, rand_win(), 4'd4, 0);
        check("err_clamp", sync_err, 1);
        send(0, 4'd0, rand_win(), 4'd4, 0);
        send(1, 4'd2, rand_win(), 4'd2, 0);
        send(0, 4'd7, rand_win(), 4'd2, 0);
        send(0, 4'd7, rand_win(), 4'd2, 0);
        send(0, 4'd7, rand_win(), 4'd2, 1);
        drain();
        check("err_sticky", sync_err, 1);

        // six-beat stream with a five-cycle output stall
        fork
            begin
                send(1, 4'd1, rand_win(), 4'd1, 0);
                send(0, 4'd3, rand_win(), 4'd1, 0);
                send(0, 4'd3, rand_win(), 4'd1, 0);
                send(0, 4'd3, rand_win(), 4'd1, 1);
                send(1, 4'd6, rand_win(), 4'd6, 0);
                send(0, 4'd0, rand_win(), 4'd6, 0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                check("stall_in_ready", in_ready, 0);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with two beats in flight
        out_ready = 1'b0;
        send(1, 4'd3, rand_win(), 4'd3, 0);
        send(0, 4'd0, rand_win(), 4'd3, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_err", sync_err, 0);
        check("mid_rst_ready", in_ready, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale", out_valid, 0);
        end
        check("post_rst_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // orphan beat with no open block
        send(0, 4'd7, rand_win(), 4'd4, 0);
        check("err_orphan", sync_err, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/quat_ip_pipe.md
QUAT_IP_PIPE -- requirements
Module: quat_ip_pipe

Interface
REQ-001 SHALL have parameter PIX_W, default 8: sample width in bits.
REQ-002 SHALL have parameter LANES, default 4: independent pixel windows processed per beat.
REQ-003 SHALL have parameter BEATS, default 4: beats per block; must be at least 1.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1: input beat present.
REQ-007 SHALL have port in_ready, output, 1: input beat accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port in_first, input, 1: marks the first beat of a block.
REQ-009 SHALL have port in_best, input, 4: best half-pel index 0..8, raster order over a 3x3 grid; sampled on first beats only.
REQ-010 SHALL have port in_win, input, LANES*25*PIX_W: per lane, a 5x5 half-pel-lattice window g[r][c], flattened raster, lane 0 in the LSBs.
REQ-011 SHALL have port out_valid, output, 1: output beat present.
REQ-012 SHALL have port out_ready, input, 1: output beat consumed when out_valid and out_ready are both high.
REQ-013 SHALL have port out_quat, output, LANES*9*PIX_W: per lane, 9 quarter-pel candidates q[0..8] in raster order.
REQ-014 SHALL have port out_last, output, 1: high on the final beat of a block.
REQ-015 SHALL have port out_best, output, 4: the effective best index used for this beat.
REQ-016 SHALL have port sync_err, output, 1: sticky framing or range error flag.

Function
REQ-017 SHALL compute the centre as cr = 1 + best/3, cc = 1 + best%3 (integer division).
REQ-018 SHALL compute, for j = 0..8 with dr = j/3 - 1 and dc = j%3 - 1: q[j] = (g[cr][cc] + g[cr+dr][cc+dc] + 1) >> 1, using a PIX_W+1-bit sum and no saturation.
REQ-019 SHALL make q[4] equal to g[cr][cc] exactly.
REQ-020 SHALL latch in_best on every accepted beat with in_first high, and apply that latched value to every later beat of the block.
REQ-021 SHALL treat an in_best value greater than 8 as 4 (clamp) and set sync_err.
REQ-022 SHALL use a two-stage pipeline: S1 registers the window selected per REQ-017; S2 registers the averages.
REQ-023 SHALL have a latency of exactly 2 cycles from input acceptance to out_valid when out_ready is held high, with a throughput of 1 beat per cycle.
REQ-024 SHALL advance a stage when it is empty or the stage downstream advances; in_ready = !S1.valid || S1 advances, and in_ready must be combinational only from out_ready and the valid registers.
REQ-025 SHALL hold out_quat, out_last and out_best stable while out_valid is high and out_ready is low.
REQ-026 SHALL count accepted beats in a counter of width clog2(BEATS), reset to 0 by an accepted first beat.
REQ-027 SHALL tag a beat as last when the count reaches BEATS-1, then wrap the count to 0.
REQ-028 SHALL, when in_first arrives with the count not equal to 0, restart the block at that beat and set sync_err.
REQ-029 SHALL, for a non-first beat accepted when no block is open, process it with best = 4 and set sync_err.
REQ-030 SHALL keep sync_err high until reset.
REQ-031 SHALL tag every beat as last when BEATS is 1.

Reset
REQ-032 SHALL, while rst_n is low, force to 0: out_valid, S1.valid, S2.valid, the beat counter, the block-open flag, sync_err, out_quat, out_last, and in_ready (in_ready returns high in the first cycle after release).
REQ-033 SHALL force the latched best to 4 while rst_n is low.
REQ-034 SHALL discard in-flight beats on reset assertion mid-block; no output beat may appear after reset release without new input.

Structure
REQ-035 SHALL place in a shared package quat_pkg: the constants NBR = 9, WIN = 25 and BEST_CTR = 4, plus the function best_to_rc.
REQ-036 SHALL implement the rounded two-input average as sub-module quat_avg (parameter PIX_W), instantiated LANES*8 times.

Verification
REQ-037 SHALL cover: PIX_W=8, g all 100 except g[1][1]=200, best=0 -> q[4]=200 and q[0..3,5..8]=150 after 2 cycles.
REQ-038 SHALL cover: g[cr][cc]=255, neighbour 254 -> q=255 (rounding up, no overflow); g[cr][cc]=0 with neighbour 1 -> q=1.
REQ-039 SHALL cover: a BEATS=4 block with best=8 on the first beat and in_best=0 on beats 2-4 -> all 4 beats use best 8, and out_last is high only on beat 4.
REQ-040 SHALL cover: out_ready low for 5 cycles during a stream of 6 beats -> no loss or duplication, outputs stable, in_ready low once both stages are full.
REQ-041 SHALL cover: in_best=12 on a first beat -> out_best=4 and sync_err=1; in_first on beat 3 -> block restarts, sync_err stays 1.
REQ-042 SHALL cover: rst_n low for 1 cycle with 2 beats in flight -> out_valid=0, sync_err=0, and no stale output after release.
